// File: rtl/morse_pkg.sv
// Shared Morse receive-path constants: symbol codes seen by the letter
// assembler and the detector FSM state encoding.
package morse_pkg;

    localparam logic [1:0] SYM_DOT    = 2'b00;
    localparam logic [1:0] SYM_DASH   = 2'b01;
    localparam logic [1:0] SYM_LETTER = 2'b10;
    localparam logic [1:0] SYM_WORD   = 2'b11;

    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_MARK  = 2'b01;
    localparam logic [1:0] ST_SPACE = 2'b10;

    function automatic logic [1:0] press_symbol(input logic is_short);
        return is_short ? SYM_DOT : SYM_DASH;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used to measure key press/release durations in ticks.
module sat_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             sclr,
    input  logic             ce,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_r;

    // Count enabled ticks, clear wins, hold at full scale
    always_ff @(posedge clk) begin
        if (sclr) begin
            cnt_r <= '0;
        end else if (ce && (cnt_r != CNT_MAX)) begin
            cnt_r <= cnt_r + CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign cnt = cnt_r;

endmodule

// File: rtl/morse_symbol_detector.sv
// Morse front end: times key presses/releases and emits DOT/DASH/LETTER_END/
// WORD_END symbols through a one-entry valid/ready output buffer.
module morse_symbol_detector
    import morse_pkg::*;
#(
    parameter int CNT_W      = 4,
    parameter int DOT_MAX    = 2,
    parameter int LETTER_GAP = 3,
    parameter int WORD_GAP   = 7
) (
    input  logic       clk,
    input  logic       sclr_n,
    input  logic       tick,
    input  logic       key,
    input  logic       sym_ready,
    output logic       sym_valid,
    output logic [1:0] sym_type,
    output logic       overrun
);

    localparam logic [CNT_W-1:0] DOT_MAX_C    = CNT_W'(DOT_MAX);
    // Gap thresholds are matched one count early so the symbol fires on the tick that reaches them
    localparam logic [CNT_W-1:0] LETTER_HIT_C = CNT_W'(LETTER_GAP - 1);
    localparam logic [CNT_W-1:0] WORD_HIT_C   = CNT_W'(WORD_GAP - 1);

    logic             key_q_r;
    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic             sym_valid_r;
    logic [1:0]       sym_type_r;
    logic             overrun_r;
    logic             rise_s;
    logic             fall_s;
    logic             cnt_clr_s;
    logic [CNT_W-1:0] cnt_s;
    logic             gen_s;
    logic [1:0]       gen_type_s;

    assign rise_s    = key & ~key_q_r;
    assign fall_s    = ~key & key_q_r;
    assign cnt_clr_s = ~sclr_n | rise_s | fall_s | (state_r == ST_IDLE);

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk  (clk),
        .sclr (cnt_clr_s),
        .ce   (tick),
        .cnt  (cnt_s)
    );

    // Next-state and symbol generation; a key edge always beats a gap tick
    always_comb begin
        state_nxt_s = state_r;
        gen_s       = 1'b0;
        gen_type_s  = SYM_DOT;
        case (state_r)
            ST_IDLE: begin
                if (rise_s) begin
                    state_nxt_s = ST_MARK;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_MARK: begin
                if (fall_s) begin
                    state_nxt_s = ST_SPACE;
                    gen_s       = 1'b1;
                    gen_type_s  = press_symbol(cnt_s <= DOT_MAX_C);
                end else begin
                    state_nxt_s = ST_MARK;
                end
            end
            ST_SPACE: begin
                if (rise_s) begin
                    state_nxt_s = ST_MARK;
                end else if (tick && (cnt_s == WORD_HIT_C)) begin
                    state_nxt_s = ST_IDLE;
                    gen_s       = 1'b1;
                    gen_type_s  = SYM_WORD;
                end else if (tick && (cnt_s == LETTER_HIT_C)) begin
                    gen_s       = 1'b1;
                    gen_type_s  = SYM_LETTER;
                end else begin
                    state_nxt_s = ST_SPACE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Key history and FSM state registers
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            key_q_r <= 1'b0;
            state_r <= ST_IDLE;
        end else begin
            key_q_r <= key;
            state_r <= state_nxt_s;
        end
    end

    // One-entry output buffer; a symbol arriving while the slot is stalled is dropped
    always_ff @(posedge clk) begin
        if (!sclr_n) begin
            sym_valid_r <= 1'b0;
            sym_type_r  <= SYM_DOT;
            overrun_r   <= 1'b0;
        end else if (gen_s) begin
            if (sym_valid_r && !sym_ready) begin
                overrun_r <= 1'b1;
            end else begin
                sym_valid_r <= 1'b1;
                sym_type_r  <= gen_type_s;
            end
        end else if (sym_valid_r && sym_ready) begin
            sym_valid_r <= 1'b0;
        end else begin
            sym_valid_r <= sym_valid_r;
        end
    end

    assign sym_valid = sym_valid_r;
    assign sym_type  = sym_type_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_morse_symbol_detector.sv
// Directed and randomized bench for morse_symbol_detector against a
// duration-based reference model of the keying rules.
module tb_morse_symbol_detector;
    import morse_pkg::*;

    localparam int CNT_MAX = 15;
    localparam int DOT_MAX = 2;
    localparam int LG      = 3;
    localparam int WG      = 7;

    logic       clk = 1'b0;
    logic       sclr_n = 1'b0;
    logic       tick = 1'b0;
    logic       key = 1'b0;
    logic       sym_ready = 1'b1;
    logic       sym_valid;
    logic [1:0] sym_type;
    logic       overrun;

    morse_symbol_detector dut (
        .clk       (clk),
        .sclr_n    (sclr_n),
        .tick      (tick),
        .key       (key),
        .sym_ready (sym_ready),
        .sym_valid (sym_valid),
        .sym_type  (sym_type),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // reference model: phase 0 idle, 1 key down, 2 key up
    int         m_phase = 0;
    int         m_dur   = 0;
    bit         m_keyq  = 1'b0;
    bit         m_valid = 1'b0;
    int         m_type  = 0;
    bit         m_ovr   = 1'b0;
    logic [1:0] rx_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] phase_code(input int p);
        if (p == 1) return ST_MARK;
        else if (p == 2) return ST_SPACE;
        else return ST_IDLE;
    endfunction

    task automatic model(input bit k, input bit rdy, input bit rst_n_v, input bit tk);
        bit rise = k && !m_keyq;
        bit fall = !k && m_keyq;
        int gen  = -1;
        int old  = m_phase;
        bit xfer;
        if (!rst_n_v) begin
            m_phase = 0; m_dur = 0; m_keyq = 1'b0;
            m_valid = 1'b0; m_type = 0; m_ovr = 1'b0;
        end else begin
            if (old == 0) begin
                if (rise) m_phase = 1;
            end else if (old == 1) begin
                if (fall) begin
                    gen = (m_dur <= DOT_MAX) ? 0 : 1;
                    m_phase = 2;
                end
            end else begin
                if (rise) m_phase = 1;
                else if (tk && (m_dur + 1 == WG)) begin gen = 3; m_phase = 0; end
                else if (tk && (m_dur + 1 == LG)) gen = 2;
            end
            if (rise || fall || old == 0) m_dur = 0;
            else if (tk && m_dur < CNT_MAX) m_dur++;
            m_keyq = k;
            xfer = m_valid && rdy;
            if (xfer) rx_q.push_back(2'(m_type));
            if (gen >= 0) begin
                if (m_valid && !rdy) m_ovr = 1'b1;
                else begin m_valid = 1'b1; m_type = gen; end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
        end
    endtask

    task automatic step(input bit k, input bit rdy, input bit rst_n_v);
        bit tk = ((cyc % 4) == 3);
        key = k; sym_ready = rdy; sclr_n = rst_n_v; tick = tk;
        model(k, rdy, rst_n_v, tk);
        @(posedge clk);
        #1;
        cyc++;
        check("sym_valid", 32'(sym_valid), 32'(m_valid));
        check("sym_type", 32'(sym_type), 32'(m_type));
        check("overrun", 32'(overrun), 32'(m_ovr));
        check("state", 32'(dut.state_r), 32'(phase_code(m_phase)));
        check("cnt", 32'(dut.cnt_s), 32'(m_dur));
    endtask

    task automatic run_ticks(input bit k, input int n, input bit rdy);
        int seen = 0;
        while (seen < n) begin
            if ((cyc % 4) == 3) seen++;
            step(k, rdy, 1'b1);
        end
    endtask

    task automatic run_pre_tick(input bit k, input bit rdy);
        while ((cyc % 4) != 3) step(k, rdy, 1'b1);
    endtask

    task automatic do_reset();
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b0);
        rx_q.delete();
    endtask

    task automatic check_rx(input string tag, input int n, input logic [7:0] exp);
        check({tag, "_len"}, 32'(rx_q.size()), 32'(n));
        for (int i = 0; i < n && i < rx_q.size(); i++)
            check({tag, "_sym"}, 32'(rx_q[i]), 32'(exp[2*i +: 2]));
    endtask

    initial begin
        logic [7:0] exp_seq;
        bit         k;
        do_reset();
        check("rst_valid", 32'(sym_valid), 32'd0);
        check("rst_state", 32'(dut.state_r), 32'(ST_IDLE));

        // short press, long release: DOT, LETTER_END, WORD_END, back to idle
        run_ticks(1'b1, 2, 1'b1);
        run_ticks(1'b0, 8, 1'b1);
        exp_seq = {2'b00, SYM_WORD, SYM_LETTER, SYM_DOT};
        check_rx("s1", 3, exp_seq);
        check("s1_idle", 32'(dut.state_r), 32'(ST_IDLE));

        // dash, one-tick gap, saturated dash
        do_reset();
        run_ticks(1'b1, 3, 1'b1);
        run_ticks(1'b0, 1, 1'b1);
        run_ticks(1'b1, 20, 1'b1);
        check("s2_sat", 32'(dut.cnt_s), 32'd15);
        run_ticks(1'b0, 8, 1'b1);
        exp_seq = {SYM_WORD, SYM_LETTER, SYM_DASH, SYM_DASH};
        check_rx("s2", 4, exp_seq);

        // rise coincides with the letter-gap tick: no LETTER_END
        do_reset();
        run_ticks(1'b1, 1, 1'b1);
        run_ticks(1'b0, 2, 1'b1);
        run_pre_tick(1'b0, 1'b1);
        step(1'b1, 1'b1, 1'b1);
        check("s3_state", 32'(dut.state_r), 32'(ST_MARK));
        check("s3_cnt", 32'(dut.cnt_s), 32'd0);
        exp_seq = {6'd0, SYM_DOT};
        check_rx("s3", 1, exp_seq);
        run_ticks(1'b1, 1, 1'b1);
        run_ticks(1'b0, 8, 1'b1);

        // stalled consumer: second DOT dropped, overrun sticky
        do_reset();
        run_ticks(1'b1, 1, 1'b0);
        run_ticks(1'b0, 1, 1'b0);
        run_ticks(1'b1, 1, 1'b0);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        check("s4_valid", 32'(sym_valid), 32'd1);
        check("s4_type", 32'(sym_type), 32'(SYM_DOT));
        check("s4_ovr", 32'(overrun), 32'd1);
        run_ticks(1'b0, 8, 1'b1);
        exp_seq = {2'b00, SYM_WORD, SYM_LETTER, SYM_DOT};
        check_rx("s4", 3, exp_seq);
        check("s4_ovr_hold", 32'(overrun), 32'd1);

        // new symbol generated in the transfer cycle is loaded, no overrun
        do_reset();
        run_ticks(1'b1, 1, 1'b0);
        run_ticks(1'b0, 2, 1'b0);
        run_pre_tick(1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        check("s5_valid", 32'(sym_valid), 32'd1);
        check("s5_type", 32'(sym_type), 32'(SYM_LETTER));
        check("s5_ovr", 32'(overrun), 32'd0);
        run_ticks(1'b0, 8, 1'b1);
        exp_seq = {2'b00, SYM_WORD, SYM_LETTER, SYM_DOT};
        check_rx("s5", 3, exp_seq);

        // reset while pressed with a pending symbol
        do_reset();
        run_ticks(1'b1, 1, 1'b0);
        run_ticks(1'b0, 1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        check("s6_valid", 32'(sym_valid), 32'd0);
        check("s6_ovr", 32'(overrun), 32'd0);
        check("s6_idle", 32'(dut.state_r), 32'(ST_IDLE));
        step(1'b1, 1'b1, 1'b1);
        check("s6_mark", 32'(dut.state_r), 32'(ST_MARK));

        // randomized keying and back-pressure
        do_reset();
        k = 1'b0;
        for (int seg = 0; seg < 150; seg++) begin
            int len = $urandom_range(1, 40);
            k = ~k;
            for (int c = 0; c < len; c++)
                step(k, ($urandom_range(0, 3) != 0), 1'b1);
        end
        run_ticks(1'b0, 10, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
